// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared types and constants for the fetch PC unit
package fetch_pc_unit_pkg;

  localparam logic [31:0] PC_INCR = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } track_entry_t;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_REDIR = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_track_fifo.sv
// rtl/fetch_track_fifo.sv - in-flight fetch tracking FIFO with flush clear
module fetch_track_fifo
  import fetch_pc_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  track_entry_t  push_data,
  input  logic          pop,
  output track_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  track_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so push is legal at full when paired with a pop.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC sequencer with branch prediction tracking and redirect
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] pred_addr,
  input  logic        pred_valid,
  input  logic        x_valid,
  input  logic        x_is_branch,
  input  logic        x_taken,
  input  logic [31:0] x_target,
  output logic [31:0] f_pc,
  output logic        f_valid,
  output logic        flush,
  output logic [15:0] mispredict_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  track_entry_t  head, push_entry;
  logic [CW-1:0] fifo_count, count_nxt;
  logic          fifo_full, fifo_empty;
  logic          push, pop, mispredict, blocked;
  logic [31:0]   redirect_pc;

  assign pop        = x_valid && !fifo_empty;
  assign mispredict = pop && ((x_is_branch && (x_taken != head.pred_taken)) ||
                              (x_taken && (x_target != head.pred_target)) ||
                              (!x_is_branch && head.pred_taken));
  assign redirect_pc = x_taken ? x_target : head.pc + PC_INCR;
  assign push        = f_valid && !stall && !mispredict;
  assign push_entry  = '{pc: f_pc, pred_taken: pred_valid, pred_target: pred_addr};
  // Look at occupancy after this edge so a pop releases fetch on the very next cycle.
  assign count_nxt   = fifo_count + CW'(push) - CW'(pop);
  assign blocked     = stall || (count_nxt == CW'(DEPTH));

  always_comb begin
    state_nxt = state;
    f_valid   = 1'b0;
    flush     = 1'b0;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        f_valid = !fifo_full;
        if (mispredict)   state_nxt = ST_REDIR;
        else if (blocked) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (mispredict)    state_nxt = ST_REDIR;
        else if (!blocked) state_nxt = ST_RUN;
      end
      ST_REDIR: begin
        flush     = 1'b1;
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_BOOT;
      f_pc           <= RESET_PC;
      mispredict_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (mispredict)  f_pc <= redirect_pc;
      else if (push)   f_pc <= pred_valid ? pred_addr : f_pc + PC_INCR;
      if (mispredict && (mispredict_cnt != 16'hFFFF))
        mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

  fetch_track_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (mispredict),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] pred_addr;
  logic        pred_valid;
  logic        x_valid;
  logic        x_is_branch;
  logic        x_taken;
  logic [31:0] x_target;
  logic [31:0] f_pc;
  logic        f_valid;
  logic        flush;
  logic [15:0] mispredict_cnt;

  int checks;
  int failures;

  fetch_pc_unit #(
    .RESET_PC (32'h0000_0100),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .pred_addr      (pred_addr),
    .pred_valid     (pred_valid),
    .x_valid        (x_valid),
    .x_is_branch    (x_is_branch),
    .x_taken        (x_taken),
    .x_target       (x_target),
    .f_pc           (f_pc),
    .f_valid        (f_valid),
    .flush          (flush),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    stall = 0; pred_addr = '0; pred_valid = 0;
    x_valid = 0; x_is_branch = 0; x_taken = 0; x_target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    stall = 1; x_valid = 1; x_is_branch = 1; x_taken = 1; x_target = 32'h900;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (f_pc !== 32'h100) begin failures++; $display("FAIL reset_pc got=%h exp=%h", f_pc, 32'h100); end
    checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL reset_fvalid got=%b exp=0", f_valid); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (mispredict_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", mispredict_cnt); end
    checks++; if (dut.fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", dut.fifo_empty); end
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_boot();
    do_reset();
    checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL boot_fvalid got=%b exp=0", f_valid); end
    x_valid = 1; x_is_branch = 1; x_taken = 1; x_target = 32'h900;
    @(negedge clk);
    x_valid = 0;
    checks++; if (f_pc !== 32'h100) begin failures++; $display("FAIL boot_pc0 got=%h exp=%h", f_pc, 32'h100); end
    checks++; if (f_valid !== 1'b1) begin failures++; $display("FAIL boot_run_fvalid got=%b exp=1", f_valid); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL empty_retire_flush got=%b exp=0", flush); end
    checks++; if (mispredict_cnt !== 16'd0) begin failures++; $display("FAIL empty_retire_cnt got=%0d exp=0", mispredict_cnt); end
    @(negedge clk);
    checks++; if (f_pc !== 32'h104) begin failures++; $display("FAIL boot_pc1 got=%h exp=%h", f_pc, 32'h104); end
    @(negedge clk);
    checks++; if (f_pc !== 32'h108) begin failures++; $display("FAIL boot_pc2 got=%h exp=%h", f_pc, 32'h108); end
  endtask

  task automatic test_predict_mispredict();
    do_reset();
    repeat (2) @(negedge clk);
    pred_valid = 1; pred_addr = 32'h200;
    @(negedge clk);
    pred_valid = 0;
    checks++; if (f_pc !== 32'h200) begin failures++; $display("FAIL pred_pc got=%h exp=%h", f_pc, 32'h200); end
    x_valid = 1; x_is_branch = 0; x_taken = 0;
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL correct_retire_flush got=%b exp=0", flush); end
    checks++; if (f_pc !== 32'h204) begin failures++; $display("FAIL correct_retire_pc got=%h exp=%h", f_pc, 32'h204); end
    x_is_branch = 1; x_taken = 0;
    @(negedge clk);
    x_valid = 0;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL mp_flush got=%b exp=1", flush); end
    checks++; if (f_pc !== 32'h108) begin failures++; $display("FAIL mp_pc got=%h exp=%h", f_pc, 32'h108); end
    checks++; if (mispredict_cnt !== 16'd1) begin failures++; $display("FAIL mp_cnt got=%0d exp=1", mispredict_cnt); end
    checks++; if (dut.fifo_empty !== 1'b1) begin failures++; $display("FAIL mp_empty got=%b exp=1", dut.fifo_empty); end
    checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL mp_fvalid got=%b exp=0", f_valid); end
    @(negedge clk);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL mp_flush_one_cycle got=%b exp=0", flush); end
    checks++; if (f_valid !== 1'b1) begin failures++; $display("FAIL mp_resume_fvalid got=%b exp=1", f_valid); end
    @(negedge clk);
    checks++; if (f_pc !== 32'h10C) begin failures++; $display("FAIL mp_resume_pc got=%h exp=%h", f_pc, 32'h10C); end
  endtask

  task automatic test_full();
    do_reset();
    repeat (5) @(negedge clk);
    checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL full_fvalid got=%b exp=0", f_valid); end
    checks++; if (f_pc !== 32'h110) begin failures++; $display("FAIL full_pc got=%h exp=%h", f_pc, 32'h110); end
    @(negedge clk);
    checks++; if (f_pc !== 32'h110) begin failures++; $display("FAIL full_hold_pc got=%h exp=%h", f_pc, 32'h110); end
    x_valid = 1; x_is_branch = 0; x_taken = 0;
    @(negedge clk);
    x_valid = 0;
    checks++; if (f_valid !== 1'b1) begin failures++; $display("FAIL full_resume_fvalid got=%b exp=1", f_valid); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL full_resume_flush got=%b exp=0", flush); end
    @(negedge clk);
    checks++; if (f_pc !== 32'h114) begin failures++; $display("FAIL full_resume_pc got=%h exp=%h", f_pc, 32'h114); end
  endtask

  task automatic test_stall_mispredict();
    do_reset();
    repeat (2) @(negedge clk);
    stall = 1; x_valid = 1; x_is_branch = 1; x_taken = 1; x_target = 32'h300;
    @(negedge clk);
    x_valid = 0;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL stall_mp_flush got=%b exp=1", flush); end
    checks++; if (f_pc !== 32'h300) begin failures++; $display("FAIL stall_mp_pc got=%h exp=%h", f_pc, 32'h300); end
    checks++; if (mispredict_cnt !== 16'd1) begin failures++; $display("FAIL stall_mp_cnt got=%0d exp=1", mispredict_cnt); end
    repeat (2) @(negedge clk);
    checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL stall_hold_fvalid got=%b exp=0", f_valid); end
    checks++; if (f_pc !== 32'h300) begin failures++; $display("FAIL stall_hold_pc got=%h exp=%h", f_pc, 32'h300); end
    stall = 0;
    @(negedge clk);
    checks++; if (f_valid !== 1'b1) begin failures++; $display("FAIL stall_drop_fvalid got=%b exp=1", f_valid); end
    @(negedge clk);
    checks++; if (f_pc !== 32'h304) begin failures++; $display("FAIL stall_drop_pc got=%h exp=%h", f_pc, 32'h304); end
  endtask

  task automatic test_target_wrap();
    do_reset();
    @(negedge clk);
    pred_valid = 1; pred_addr = 32'h200;
    @(negedge clk);
    pred_valid = 0;
    x_valid = 1; x_is_branch = 1; x_taken = 1; x_target = 32'hFFFF_FFFC;
    @(negedge clk);
    x_valid = 0;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL tgt_mp_flush got=%b exp=1", flush); end
    checks++; if (f_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL tgt_mp_pc got=%h exp=%h", f_pc, 32'hFFFF_FFFC); end
    repeat (2) @(negedge clk);
    checks++; if (f_pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", f_pc, 32'h0); end
  endtask

  task automatic test_nonbranch_pred();
    do_reset();
    @(negedge clk);
    pred_valid = 1; pred_addr = 32'h500;
    @(negedge clk);
    pred_valid = 0;
    x_valid = 1; x_is_branch = 0; x_taken = 0;
    @(negedge clk);
    x_valid = 0;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL nb_flush got=%b exp=1", flush); end
    checks++; if (f_pc !== 32'h104) begin failures++; $display("FAIL nb_pc got=%h exp=%h", f_pc, 32'h104); end
    checks++; if (mispredict_cnt !== 16'd1) begin failures++; $display("FAIL nb_cnt got=%0d exp=1", mispredict_cnt); end
  endtask

  task automatic test_reset_override();
    do_reset();
    repeat (5) @(negedge clk);
    x_valid = 1; x_is_branch = 1; x_taken = 1; x_target = 32'h700;
    rst_n = 0;
    @(negedge clk);
    checks++; if (f_pc !== 32'h100) begin failures++; $display("FAIL rst_full_pc got=%h exp=%h", f_pc, 32'h100); end
    checks++; if (dut.fifo_empty !== 1'b1) begin failures++; $display("FAIL rst_full_empty got=%b exp=1", dut.fifo_empty); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_full_flush got=%b exp=0", flush); end
    rst_n = 1; x_valid = 0;
    repeat (5) @(negedge clk);
    x_valid = 1;
    @(negedge clk);
    x_valid = 0;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL redir_flush got=%b exp=1", flush); end
    checks++; if (mispredict_cnt !== 16'd1) begin failures++; $display("FAIL redir_cnt got=%0d exp=1", mispredict_cnt); end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    checks++; if (f_pc !== 32'h100) begin failures++; $display("FAIL rst_redir_pc got=%h exp=%h", f_pc, 32'h100); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_redir_flush got=%b exp=0", flush); end
    checks++; if (mispredict_cnt !== 16'd0) begin failures++; $display("FAIL rst_redir_cnt got=%0d exp=0", mispredict_cnt); end
    checks++; if (dut.fifo_empty !== 1'b1) begin failures++; $display("FAIL rst_redir_empty got=%b exp=1", dut.fifo_empty); end
    checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL rst_redir_fvalid got=%b exp=0", f_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_boot();
    test_predict_mispredict();
    test_full();
    test_stall_mispredict();
    test_target_wrap();
    test_nonbranch_pred();
    test_reset_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
